// File: rtl/mem_wb_stage.sv
// mem_wb_stage: consumer end of the EX/MEM pipeline register.
// Resolves the branch, runs the req/ack data-memory handshake,
// stalls upstream while an access is outstanding, and registers
// the MEM/WB fields for write-back.
// Optional feature: define MEM_TIMEOUT_EN to abort accesses that are
// not acknowledged within TIMEOUT_CYCLES and raise a sticky bus_err.
module mem_wb_stage #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_adder,
    input  logic [DATA_W-1:0] ex_alu,
    input  logic              ex_zf,
    input  logic [DATA_W-1:0] ex_rd2,
    input  logic [1:0]        ex_wb,
    input  logic [2:0]        ex_m,
    input  logic [4:0]        ex_dst,
    output logic              stall,
    output logic              pc_src,
    output logic [DATA_W-1:0] branch_target,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
`ifdef MEM_TIMEOUT_EN
    output logic              bus_err,
`endif
    output logic              wb_valid,
    output logic [1:0]        wb_ctrl,
    output logic [DATA_W-1:0] wb_rdata,
    output logic [DATA_W-1:0] wb_alu,
    output logic [4:0]        wb_dst
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]        lat_wb_q, lat_wb_d;
    logic [DATA_W-1:0] lat_alu_q, lat_alu_d;
    logic [4:0]        lat_dst_q, lat_dst_d;
    logic              wb_valid_q, wb_valid_d;
    logic [1:0]        wb_ctrl_q, wb_ctrl_d;
    logic [DATA_W-1:0] wb_rdata_q, wb_rdata_d;
    logic [DATA_W-1:0] wb_alu_q, wb_alu_d;
    logic [4:0]        wb_dst_q, wb_dst_d;
    logic              memop;
    logic              timeout_hit;

`ifdef MEM_TIMEOUT_EN
    logic [7:0]        tmo_cnt_q, tmo_cnt_d;
    logic              bus_err_q, bus_err_d;

    // Abort fires in the last ACCESS cycle that still has no ack
    assign timeout_hit = (state_q == ACCESS) && !mem_ack &&
                         (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1));
    assign bus_err     = bus_err_q;
`else
    assign timeout_hit = 1'b0;
`endif

    assign memop         = ex_valid & (ex_m[1] | ex_m[0]);
    assign pc_src        = ex_valid & ex_m[2] & ex_zf;
    assign branch_target = ex_adder;
    assign stall         = ((state_q == IDLE) & memop) |
                           ((state_q == ACCESS) & ~mem_ack & ~timeout_hit);

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_ctrl   = wb_ctrl_q;
    assign wb_rdata  = wb_rdata_q;
    assign wb_alu    = wb_alu_q;
    assign wb_dst    = wb_dst_q;

    // Next-state and next-output logic for the IDLE/ACCESS handshake FSM
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        lat_wb_d    = lat_wb_q;
        lat_alu_d   = lat_alu_q;
        lat_dst_d   = lat_dst_q;
        wb_valid_d  = wb_valid_q;
        wb_ctrl_d   = wb_ctrl_q;
        wb_rdata_d  = wb_rdata_q;
        wb_alu_d    = wb_alu_q;
        wb_dst_d    = wb_dst_q;
`ifdef MEM_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        bus_err_d   = bus_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (memop) begin
                    state_d     = ACCESS;
                    mem_req_d   = 1'b1;
                    mem_we_d    = ex_m[0];
                    mem_addr_d  = ex_alu;
                    mem_wdata_d = ex_rd2;
                    lat_wb_d    = ex_wb;
                    lat_alu_d   = ex_alu;
                    lat_dst_d   = ex_dst;
                    wb_valid_d  = 1'b0;
`ifdef MEM_TIMEOUT_EN
                    tmo_cnt_d   = 8'd0;
`endif
                end else begin
                    wb_valid_d  = ex_valid;
                    wb_ctrl_d   = ex_wb;
                    wb_alu_d    = ex_alu;
                    wb_dst_d    = ex_dst;
                    wb_rdata_d  = '0;
                end
            end
            ACCESS: begin
                wb_valid_d = 1'b0;
                if (mem_ack) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    wb_rdata_d = mem_we_q ? '0 : mem_rdata;
                    wb_ctrl_d  = lat_wb_q;
                    wb_alu_d   = lat_alu_q;
                    wb_dst_d   = lat_dst_q;
                    wb_valid_d = 1'b1;
                end else if (timeout_hit) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    wb_rdata_d = '0;
                    wb_ctrl_d  = 2'b00;
                    wb_alu_d   = lat_alu_q;
                    wb_dst_d   = lat_dst_q;
                    wb_valid_d = 1'b1;
`ifdef MEM_TIMEOUT_EN
                    bus_err_d  = 1'b1;
`endif
                end else begin
`ifdef MEM_TIMEOUT_EN
                    tmo_cnt_d  = tmo_cnt_q + 8'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; async reset abandons any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            lat_wb_q    <= 2'b00;
            lat_alu_q   <= '0;
            lat_dst_q   <= 5'd0;
            wb_valid_q  <= 1'b0;
            wb_ctrl_q   <= 2'b00;
            wb_rdata_q  <= '0;
            wb_alu_q    <= '0;
            wb_dst_q    <= 5'd0;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt_q   <= 8'd0;
            bus_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            lat_wb_q    <= lat_wb_d;
            lat_alu_q   <= lat_alu_d;
            lat_dst_q   <= lat_dst_d;
            wb_valid_q  <= wb_valid_d;
            wb_ctrl_q   <= wb_ctrl_d;
            wb_rdata_q  <= wb_rdata_d;
            wb_alu_q    <= wb_alu_d;
            wb_dst_q    <= wb_dst_d;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            bus_err_q   <= bus_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: table of single-cycle vectors plus
// hand-written load/store/reset (and timeout) sequences.
module tb_mem_wb_stage;

`ifdef MEM_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 16;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_zf;
    logic [31:0] ex_adder, ex_alu, ex_rd2;
    logic [1:0]  ex_wb;
    logic [2:0]  ex_m;
    logic [4:0]  ex_dst;
    logic        stall, pc_src, mem_req, mem_we, mem_ack;
    logic [31:0] branch_target, mem_addr, mem_wdata, mem_rdata;
    logic        wb_valid;
    logic [1:0]  wb_ctrl;
    logic [31:0] wb_rdata, wb_alu;
    logic [4:0]  wb_dst;
`ifdef MEM_TIMEOUT_EN
    logic        bus_err;
`endif

    int tests = 0;
    int fails = 0;

    mem_wb_stage #(.DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_adder(ex_adder), .ex_alu(ex_alu),
        .ex_zf(ex_zf), .ex_rd2(ex_rd2), .ex_wb(ex_wb), .ex_m(ex_m),
        .ex_dst(ex_dst), .stall(stall), .pc_src(pc_src),
        .branch_target(branch_target), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack),
`ifdef MEM_TIMEOUT_EN
        .bus_err(bus_err),
`endif
        .wb_valid(wb_valid), .wb_ctrl(wb_ctrl), .wb_rdata(wb_rdata),
        .wb_alu(wb_alu), .wb_dst(wb_dst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [2:0]  m;
        logic [1:0]  wb;
        logic [31:0] alu;
        logic [4:0]  dst;
        logic        zf;
        logic [31:0] adder;
        logic        ack;
        logic        e_pc_src;
        logic        e_wb_valid;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] m, input logic [1:0] wb,
                                 input logic [31:0] alu, input logic [31:0] rd2,
                                 input logic [31:0] adder, input logic zf, input logic [4:0] dst);
        ex_valid = v; ex_m = m; ex_wb = wb; ex_alu = alu;
        ex_rd2 = rd2; ex_adder = adder; ex_zf = zf; ex_dst = dst;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            v  m       wb     alu            dst    zf    adder          ack  pc  wbv
        vecs[0] = '{1'b1, 3'b000, 2'b10, 32'h0000_0055, 5'd9,  1'b0, 32'h0,         1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 3'b100, 2'b00, 32'h0000_0000, 5'd0,  1'b1, 32'h0000_0040, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 3'b100, 2'b00, 32'h0000_0001, 5'd0,  1'b0, 32'h0000_0040, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 3'b100, 2'b11, 32'h0000_0007, 5'd3,  1'b1, 32'h0000_0080, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 3'b010, 2'b01, 32'h0000_0100, 5'd4,  1'b0, 32'h0,         1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 3'b000, 2'b11, 32'hFFFF_FFFF, 5'd31, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        applyStimulus(1'b0, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
        tick; tick;
        checkOutput("reset mem_req", {31'b0, mem_req}, 32'h0);
        checkOutput("reset mem_addr", mem_addr, 32'h0);
        checkOutput("reset wb_valid", {31'b0, wb_valid}, 32'h0);
        checkOutput("reset wb_alu", wb_alu, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].v, vecs[i].m, vecs[i].wb, vecs[i].alu, 32'hAAAA_0000,
                          vecs[i].adder, vecs[i].zf, vecs[i].dst);
            mem_ack = vecs[i].ack;
            @(negedge clk);
            checkOutput($sformatf("vec%0d pc_src", i), {31'b0, pc_src}, {31'b0, vecs[i].e_pc_src});
            checkOutput($sformatf("vec%0d branch_target", i), branch_target, vecs[i].adder);
            checkOutput($sformatf("vec%0d stall", i), {31'b0, stall}, 32'h0);
            tick;
            checkOutput($sformatf("vec%0d mem_req", i), {31'b0, mem_req}, 32'h0);
            checkOutput($sformatf("vec%0d wb_valid", i), {31'b0, wb_valid}, {31'b0, vecs[i].e_wb_valid});
            checkOutput($sformatf("vec%0d wb_ctrl", i), {30'b0, wb_ctrl}, {30'b0, vecs[i].wb});
            checkOutput($sformatf("vec%0d wb_alu", i), wb_alu, vecs[i].alu);
            checkOutput($sformatf("vec%0d wb_dst", i), {27'b0, wb_dst}, {27'b0, vecs[i].dst});
            checkOutput($sformatf("vec%0d wb_rdata", i), wb_rdata, 32'h0);
        end
        mem_ack = 1'b0;

        // Load: three ACCESS cycles without ack, ack in the fourth
        applyStimulus(1'b1, 3'b010, 2'b11, 32'h0000_0100, 32'h0, 32'h0, 1'b0, 5'd5);
        @(negedge clk);
        checkOutput("load idle stall", {31'b0, stall}, 32'h1);
        tick;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput($sformatf("load wait%0d stall", c), {31'b0, stall}, 32'h1);
            checkOutput($sformatf("load wait%0d mem_req", c), {31'b0, mem_req}, 32'h1);
            checkOutput($sformatf("load wait%0d mem_we", c), {31'b0, mem_we}, 32'h0);
            checkOutput($sformatf("load wait%0d mem_addr", c), mem_addr, 32'h0000_0100);
            tick;
            checkOutput($sformatf("load wait%0d wb_valid", c), {31'b0, wb_valid}, 32'h0);
        end
        mem_ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checkOutput("load ack stall", {31'b0, stall}, 32'h0);
        tick;
        mem_ack = 1'b0;
        checkOutput("load mem_req", {31'b0, mem_req}, 32'h0);
        checkOutput("load wb_valid", {31'b0, wb_valid}, 32'h1);
        checkOutput("load wb_rdata", wb_rdata, 32'hDEAD_BEEF);
        checkOutput("load wb_ctrl", {30'b0, wb_ctrl}, 32'h3);
        checkOutput("load wb_alu", wb_alu, 32'h0000_0100);
        checkOutput("load wb_dst", {27'b0, wb_dst}, 32'd5);
        applyStimulus(1'b0, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
        tick;
        checkOutput("load wb_valid one cycle", {31'b0, wb_valid}, 32'h0);

        // Store with ack in the first ACCESS cycle; both mem bits set on the second
        for (int s = 0; s < 2; s++) begin
            applyStimulus(1'b1, (s == 0) ? 3'b001 : 3'b011, 2'b00, 32'h0000_0020,
                          32'h0000_1234, 32'h0, 1'b0, 5'd0);
            tick;
            checkOutput($sformatf("store%0d mem_req", s), {31'b0, mem_req}, 32'h1);
            checkOutput($sformatf("store%0d mem_we", s), {31'b0, mem_we}, 32'h1);
            checkOutput($sformatf("store%0d mem_wdata", s), mem_wdata, 32'h0000_1234);
            checkOutput($sformatf("store%0d mem_addr", s), mem_addr, 32'h0000_0020);
            mem_ack = 1'b1;
            mem_rdata = 32'hFFFF_FFFF;
            @(negedge clk);
            checkOutput($sformatf("store%0d ack stall", s), {31'b0, stall}, 32'h0);
            tick;
            mem_ack = 1'b0;
            checkOutput($sformatf("store%0d mem_req done", s), {31'b0, mem_req}, 32'h0);
            checkOutput($sformatf("store%0d wb_valid", s), {31'b0, wb_valid}, 32'h1);
            checkOutput($sformatf("store%0d wb_rdata", s), wb_rdata, 32'h0);
        end

`ifdef MEM_TIMEOUT_EN
        // Load never acknowledged: abort after TMO ACCESS cycles
        applyStimulus(1'b1, 3'b010, 2'b10, 32'h0000_0300, 32'h0, 32'h0, 1'b0, 5'd7);
        tick;
        for (int c = 0; c < TMO - 1; c++) begin
            @(negedge clk);
            checkOutput($sformatf("tmo wait%0d stall", c), {31'b0, stall}, 32'h1);
            tick;
            checkOutput($sformatf("tmo wait%0d mem_req", c), {31'b0, mem_req}, 32'h1);
        end
        @(negedge clk);
        checkOutput("tmo abort stall", {31'b0, stall}, 32'h0);
        tick;
        checkOutput("tmo mem_req", {31'b0, mem_req}, 32'h0);
        checkOutput("tmo bus_err", {31'b0, bus_err}, 32'h1);
        checkOutput("tmo wb_valid", {31'b0, wb_valid}, 32'h1);
        checkOutput("tmo wb_ctrl", {30'b0, wb_ctrl}, 32'h0);
        applyStimulus(1'b0, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
        tick;
        checkOutput("tmo bus_err sticky", {31'b0, bus_err}, 32'h1);
`endif

        // Reset in the middle of an access drops mem_req at once
        applyStimulus(1'b1, 3'b010, 2'b11, 32'h0000_0200, 32'h0, 32'h0, 1'b0, 5'd6);
        tick;
        checkOutput("midreset mem_req before", {31'b0, mem_req}, 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset mem_req", {31'b0, mem_req}, 32'h0);
        checkOutput("midreset wb_ctrl", {30'b0, wb_ctrl}, 32'h0);
        checkOutput("midreset wb_rdata", wb_rdata, 32'h0);
        checkOutput("midreset wb_dst", {27'b0, wb_dst}, 32'h0);
        applyStimulus(1'b0, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
        tick;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midreset idle stall", {31'b0, stall}, 32'h0);
        tick;
        checkOutput("midreset wb_valid", {31'b0, wb_valid}, 32'h0);
        checkOutput("midreset mem_req after", {31'b0, mem_req}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
